push_debouncer: RTL and testbench

//  Conditions the raw board push buttons (arriba, abajo, izquierda, derecha, centro) before they reach the top level.
//  Per button: 2-FF synchroniser, debounce filter, one-cycle press pulse, hold-to-repeat pulses, one-cycle release pulse.

---
 rtl/push_debouncer_pkg.sv | 23 ++
 rtl/push_debouncer_if.sv | 21 ++
 rtl/push_debouncer_channel.sv | 133 +++++++++++++
 rtl/push_debouncer.sv | 43 ++++
 tb/tb_push_debouncer.sv | 191 +++++++++++++++++++
 5 files changed

// File: rtl/push_debouncer_pkg.sv
// Shared definitions for the push-button conditioning block:
// channel state encoding and button index constants.
package push_pkg;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        CONF_ON  = 3'd1,
        HELD     = 3'd2,
        REPEAT   = 3'd3,
        CONF_OFF = 3'd4
    } state_t;

    localparam int BTN_ARRIBA    = 0;
    localparam int BTN_ABAJO     = 1;
    localparam int BTN_IZQUIERDA = 2;
    localparam int BTN_DERECHA   = 3;
    localparam int BTN_CENTRO    = 4;

    // Only the up/down buttons auto-repeat (value inc/dec while held).
    localparam logic [4:0] DEFAULT_REPEAT_MASK =
        5'((1 << BTN_ARRIBA) | (1 << BTN_ABAJO));

endpackage

// File: rtl/push_debouncer_if.sv
// Button bundle between the board pins / consumers and the conditioner.
interface push_debouncer_if #(
    parameter int N_BTN = 5
);
    logic [N_BTN-1:0] btn_raw;
    logic             enable;
    logic [N_BTN-1:0] btn_level;
    logic [N_BTN-1:0] btn_pulse;
    logic [N_BTN-1:0] btn_release;
    logic             any_pressed;

    modport master (
        output btn_raw, enable,
        input  btn_level, btn_pulse, btn_release, any_pressed
    );

    modport slave (
        input  btn_raw, enable,
        output btn_level, btn_pulse, btn_release, any_pressed
    );
endinterface

// File: rtl/push_debouncer_channel.sv
// One button: 2-FF synchroniser, debounce/repeat FSM with a saturating
// counter, and registered level / press-pulse / release-pulse outputs.
module push_debounce_channel
    import push_pkg::*;
#(
    parameter int DEB_CYC   = 2_000_000,
    parameter int REP_DELAY = 50_000_000,
    parameter int REP_RATE  = 10_000_000,
    parameter bit REPEAT_EN = 1'b0,
    parameter int CNT_W     = 26
) (
    input  logic clk,
    input  logic Reset_n,
    input  logic raw,
    output logic level,
    output logic press_pulse,
    output logic rel_pulse
);

    localparam logic [CNT_W-1:0] DEB_LAST   = CNT_W'(DEB_CYC - 1);
    localparam logic [CNT_W-1:0] DELAY_LAST = CNT_W'(REP_DELAY - 1);
    localparam logic [CNT_W-1:0] RATE_LAST  = CNT_W'(REP_RATE - 1);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    logic             sync_p0, sync_p1;
    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic             rep_mem, rep_mem_nxt;
    logic             level_nxt, press_nxt, rel_nxt;

    // Synchroniser, FSM state, counter and registered outputs.
    always_ff @(posedge clk) begin
        if (!Reset_n) begin
            sync_p0     <= 1'b0;
            sync_p1     <= 1'b0;
            state       <= IDLE;
            cnt         <= '0;
            rep_mem     <= 1'b0;
            level       <= 1'b0;
            press_pulse <= 1'b0;
            rel_pulse   <= 1'b0;
        end else begin
            sync_p0     <= raw;
            sync_p1     <= sync_p0;
            state       <= state_nxt;
            cnt         <= cnt_nxt;
            rep_mem     <= rep_mem_nxt;
            level       <= level_nxt;
            press_pulse <= press_nxt;
            rel_pulse   <= rel_nxt;
        end
    end

    // Next state: qualify press/release for DEB_CYC cycles, repeat while held.
    // DEB_CYC=1 accepts a level straight from IDLE/HELD/REPEAT with no confirm state.
    always_comb begin
        state_nxt   = state;
        cnt_nxt     = sat_inc(cnt);
        rep_mem_nxt = rep_mem;
        level_nxt   = level;
        press_nxt   = 1'b0;
        rel_nxt     = 1'b0;
        case (state)
            IDLE: begin
                cnt_nxt = '0;
                if (sync_p1) begin
                    if (DEB_CYC <= 1) begin
                        state_nxt   = HELD;
                        rep_mem_nxt = 1'b0;
                        level_nxt   = 1'b1;
                        press_nxt   = 1'b1;
                    end else begin
                        state_nxt = CONF_ON;
                        cnt_nxt   = CNT_ONE;
                    end
                end
            end
            CONF_ON: begin
                if (!sync_p1) begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                end else if (cnt == DEB_LAST) begin
                    state_nxt   = HELD;
                    cnt_nxt     = '0;
                    rep_mem_nxt = 1'b0;
                    level_nxt   = 1'b1;
                    press_nxt   = 1'b1;
                end
            end
            HELD, REPEAT: begin
                if (!sync_p1) begin
                    rep_mem_nxt = (state == REPEAT);
                    if (DEB_CYC <= 1) begin
                        state_nxt = IDLE;
                        cnt_nxt   = '0;
                        level_nxt = 1'b0;
                        rel_nxt   = 1'b1;
                    end else begin
                        state_nxt = CONF_OFF;
                        cnt_nxt   = CNT_ONE;
                    end
                end else if (state == HELD && REPEAT_EN && cnt == DELAY_LAST) begin
                    state_nxt = REPEAT;
                    cnt_nxt   = '0;
                    press_nxt = 1'b1;
                end else if (state == REPEAT && cnt == RATE_LAST) begin
                    cnt_nxt   = '0;
                    press_nxt = 1'b1;
                end
            end
            CONF_OFF: begin
                if (sync_p1) begin
                    state_nxt = rep_mem ? REPEAT : HELD;
                    cnt_nxt   = '0;
                end else if (cnt == DEB_LAST) begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                    level_nxt = 1'b0;
                    rel_nxt   = 1'b1;
                end
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

endmodule

// File: rtl/push_debouncer.sv
// Push-button conditioner: one debounce channel per button, auto-repeat
// enabled per REPEAT_MASK, pulses gated by enable, any_pressed summary.
module push_debouncer
    import push_pkg::*;
#(
    parameter int               N_BTN       = 5,
    parameter int               DEB_CYC     = 2_000_000,
    parameter int               REP_DELAY   = 50_000_000,
    parameter int               REP_RATE    = 10_000_000,
    parameter logic [N_BTN-1:0] REPEAT_MASK = N_BTN'(DEFAULT_REPEAT_MASK),
    parameter int               CNT_W       = 26
) (
    input  logic            clk,
    input  logic            Reset_n,
    push_debouncer_if.slave bus
);

    logic [N_BTN-1:0] level, pulse, rel;

    for (genvar i = 0; i < N_BTN; i++) begin : g_ch
        push_debounce_channel #(
            .DEB_CYC   (DEB_CYC),
            .REP_DELAY (REP_DELAY),
            .REP_RATE  (REP_RATE),
            .REPEAT_EN (REPEAT_MASK[i]),
            .CNT_W     (CNT_W)
        ) u_ch (
            .clk         (clk),
            .Reset_n     (Reset_n),
            .raw         (bus.btn_raw[i]),
            .level       (level[i]),
            .press_pulse (pulse[i]),
            .rel_pulse   (rel[i])
        );
    end

    // Level keeps tracking while disabled; only the event pulses are suppressed.
    assign bus.btn_level   = level;
    assign bus.btn_pulse   = pulse & {N_BTN{bus.enable}};
    assign bus.btn_release = rel & {N_BTN{bus.enable}};
    assign bus.any_pressed = |level;

endmodule

// File: tb/tb_push_debouncer.sv
// Directed bench for push_debouncer with short debounce/repeat timings.
module tb_push_debouncer;
    localparam int N = 5;

    logic clk = 1'b0;
    logic Reset_n;

    push_debouncer_if #(.N_BTN(N)) bus ();

    push_debouncer #(
        .N_BTN       (N),
        .DEB_CYC     (4),
        .REP_DELAY   (20),
        .REP_RATE    (8),
        .REPEAT_MASK (5'b00011),
        .CNT_W       (8)
    ) dut (
        .clk     (clk),
        .Reset_n (Reset_n),
        .bus     (bus.slave)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int tidx;
    int ptimes[N][$];
    int pcnt[N], lcnt[N], rcnt[N];
    int acnt;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic int pt(input int b, input int k);
        return (k < ptimes[b].size()) ? ptimes[b][k] : -1;
    endfunction

    task automatic clr();
        tidx = 0;
        acnt = 0;
        for (int i = 0; i < N; i++) begin
            ptimes[i].delete();
            pcnt[i] = 0;
            lcnt[i] = 0;
            rcnt[i] = 0;
        end
    endtask

    // Advance n clock edges, sampling 1 time unit after each rising edge.
    task automatic run(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            tidx++;
            for (int i = 0; i < N; i++) begin
                if (bus.btn_pulse[i] === 1'b1) begin
                    pcnt[i]++;
                    ptimes[i].push_back(tidx);
                end
                if (bus.btn_level[i] === 1'b1) lcnt[i]++;
                if (bus.btn_release[i] === 1'b1) rcnt[i]++;
            end
            if (bus.any_pressed === 1'b1) acnt++;
        end
    endtask

    initial begin
        int b3[5];
        int e4[6];
        int e5[4];
        b3 = '{1, 0, 1, 1, 0};
        e4 = '{6, 26, 34, 42, 50, 58};
        e5 = '{6, 26, 34, 49};

        // 1: reset with all buttons held, then release reset
        Reset_n     = 1'b0;
        bus.btn_raw = 5'h1F;
        bus.enable  = 1'b1;
        clr();
        run(3);
        chk("rst_level", 32'(bus.btn_level), 0);
        chk("rst_pulse", 32'(bus.btn_pulse), 0);
        chk("rst_release", 32'(bus.btn_release), 0);
        chk("rst_any", 32'(bus.any_pressed), 0);
        Reset_n = 1'b1;
        clr();
        run(5);
        chk("t1_pulse_early", 32'(bus.btn_pulse), 0);
        run(1);
        chk("t1_pulse_at6", 32'(bus.btn_pulse), 32'h1F);
        chk("t1_level_at6", 32'(bus.btn_level), 32'h1F);
        chk("t1_any_at6", 32'(bus.any_pressed), 1);
        bus.btn_raw = 5'h00;
        clr();
        run(5);
        chk("t1_rel_early", 32'(bus.btn_release), 0);
        chk("t1_level_hold", 32'(bus.btn_level), 32'h1F);
        run(1);
        chk("t1_rel_at6", 32'(bus.btn_release), 32'h1F);
        chk("t1_level_off", 32'(bus.btn_level), 0);
        run(1);
        chk("t1_rel_once", 32'(bus.btn_release), 0);
        run(5);

        // 2: clean press of centro, no repeat
        clr();
        bus.btn_raw = 5'h10;
        run(30);
        bus.btn_raw = 5'h00;
        run(20);
        chk("t2_npulse", pcnt[4], 1);
        chk("t2_pulse_t", pt(4, 0), 6);
        chk("t2_level_len", lcnt[4], 30);
        chk("t2_nrel", rcnt[4], 1);
        chk("t2_any_len", acnt, 30);
        chk("t2_other", pcnt[0] + pcnt[1] + pcnt[2] + pcnt[3], 0);

        // 3: bouncing izquierda then stable
        clr();
        for (int i = 0; i < 5; i++) begin
            bus.btn_raw[2] = b3[i][0];
            run(1);
        end
        bus.btn_raw[2] = 1'b1;
        run(10);
        chk("t3_npulse", pcnt[2], 1);
        chk("t3_pulse_t", pt(2, 0), 11);
        bus.btn_raw = 5'h00;
        run(10);
        chk("t3_nrel", rcnt[2], 1);

        // 4: auto-repeat on arriba
        clr();
        bus.btn_raw = 5'h01;
        run(62);
        bus.btn_raw = 5'h00;
        run(20);
        chk("t4_npulse", pcnt[0], 6);
        for (int i = 0; i < 6; i++) chk($sformatf("t4_pulse_t%0d", i), pt(0, i), e4[i]);
        chk("t4_nrel", rcnt[0], 1);
        chk("t4_level_len", lcnt[0], 62);

        // 5: release glitch while repeating
        clr();
        bus.btn_raw = 5'h01;
        run(36);
        bus.btn_raw = 5'h00;
        run(2);
        bus.btn_raw = 5'h01;
        run(12);
        chk("t5_npulse", pcnt[0], 4);
        for (int i = 0; i < 4; i++) chk($sformatf("t5_pulse_t%0d", i), pt(0, i), e5[i]);
        chk("t5_level_len", lcnt[0], 45);
        chk("t5_no_rel", rcnt[0], 0);
        bus.btn_raw = 5'h00;
        run(10);
        chk("t5_nrel", rcnt[0], 1);
        chk("t5_npulse_end", pcnt[0], 4);

        // 6: simultaneous press and enable gating of repeats
        clr();
        bus.btn_raw = 5'h03;
        run(6);
        chk("t6_simul", 32'(bus.btn_pulse), 32'h03);
        bus.enable = 1'b0;
        run(40);
        chk("t6_gated0", pcnt[0], 1);
        chk("t6_gated1", pcnt[1], 1);
        chk("t6_level0", lcnt[0], 41);
        chk("t6_level1", lcnt[1], 41);
        bus.enable = 1'b1;
        run(8);
        chk("t6_resume0", pcnt[0], 2);
        chk("t6_resume_t", pt(0, 1), 50);
        chk("t6_resume1", pcnt[1], 2);
        bus.btn_raw = 5'h00;
        run(12);
        chk("t6_rel0", rcnt[0], 1);
        chk("t6_rel1", rcnt[1], 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
